// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, field positions and latch bundle.
// Used by the interlock controller and its RAW pair checkers.
package pipe_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;

  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [3:0]  RA_IDX   = 4'd15;
  localparam logic [31:0] NOP_WORD = 32'h6800_0000;

  typedef struct packed {
    logic [31:0] of;
    logic [31:0] ex;
    logic [31:0] ma;
    logic [31:0] rw;
  } pipe_latch_t;

  function automatic logic [4:0] opc(input logic [31:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/raw_pair_check.sv
// RAW conflict between the OF instruction (a) and one downstream latch (b).
// Only rs1 is interlocked; rs2 and store data go through forwarding.
module raw_pair_check
  import pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        conflict
);

  logic [4:0] a_op;
  logic [4:0] b_op;
  logic       a_no_read;
  logic       b_no_write;
  logic [3:0] src;
  logic [3:0] dest;

  always_comb begin
    a_op = opc(a);
    b_op = opc(b);
    a_no_read = a_op inside {OP_NOP, OP_BEQ, OP_BGT, OP_B,
                             OP_CALL, OP_NOT, OP_MOV};
    b_no_write = b_op inside {OP_NOP, OP_CMP, OP_ST, OP_BEQ,
                              OP_BGT, OP_B, OP_RET};
    // RET reads and CALL writes the link register implicitly
    src  = (a_op == OP_RET) ? RA_IDX : a[RS1_HI:RS1_LO];
    dest = (b_op == OP_CALL) ? RA_IDX : b[RD_HI:RD_LO];
    conflict = !a_no_read && !b_no_write && (src == dest);
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Stall/flush controller owning the IF/OF..MA/RW instruction latches.
// Branch flush outranks a RAW stall; stalls are counted with saturation.
module pipeline_interlock #(
  parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_WORD,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_instr,
  input  logic             branch_taken,
  output logic             pc_stall,
  output logic [31:0]      of_instr,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ma_instr,
  output logic [31:0]      rw_instr,
  output logic [CNT_W-1:0] stall_cnt
);

  import pipe_pkg::pipe_latch_t;

  pipe_latch_t      lat;
  logic [CNT_W-1:0] cnt;
  logic             c_ex;
  logic             c_ma;
  logic             c_rw;
  logic             conflict;

  raw_pair_check u_chk_ex (.a(lat.of), .b(lat.ex), .conflict(c_ex));
  raw_pair_check u_chk_ma (.a(lat.of), .b(lat.ma), .conflict(c_ma));
  raw_pair_check u_chk_rw (.a(lat.of), .b(lat.rw), .conflict(c_rw));

  assign conflict = c_ex | c_ma | c_rw;
  assign pc_stall = conflict & ~branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat.of <= NOP_WORD;
      lat.ex <= NOP_WORD;
      lat.ma <= NOP_WORD;
      lat.rw <= NOP_WORD;
      cnt    <= '0;
    end else begin
      lat.ma <= lat.ex;
      lat.rw <= lat.ma;
      if (branch_taken) begin
        lat.of <= NOP_WORD;
        lat.ex <= NOP_WORD;
      end else if (conflict) begin
        lat.ex <= NOP_WORD;
        if (~&cnt) cnt <= cnt + 1'b1;
      end else begin
        lat.of <= if_instr;
        lat.ex <= lat.of;
      end
    end
  end

  assign of_instr  = lat.of;
  assign ex_instr  = lat.ex;
  assign ma_instr  = lat.ma;
  assign rw_instr  = lat.rw;
  assign stall_cnt = cnt;

endmodule

// File: doc/pipeline_interlock.md
# pipeline_interlock

Stall/flush controller for the 5-stage in-order pipeline (IF, OF, EX, MA, RW). It owns the instruction latches between stages and consumes the per-pair RAW conflict check. When the instruction in OF reads a register still being produced downstream, it freezes PC and the IF/OF latch and injects NOP bubbles into EX. When EX resolves a taken branch, it squashes the two younger instructions.

## Interface
- `NOP_WORD`, default 32'h6800_0000: bubble encoding (opcode 5'b01101 in [31:27], all other bits 0).
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_instr`  in  32  instruction fetched this cycle.
- `branch_taken`  in  1  EX-stage branch/call/ret resolved taken this cycle.
- `pc_stall`  out  1  hold PC and fetch this cycle.
- `of_instr`  out  32  IF/OF latch.
- `ex_instr`  out  32  OF/EX latch.
- `ma_instr`  out  32  EX/MA latch.
- `rw_instr`  out  32  MA/RW latch.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles since reset.

## Operation
Instruction fields:
- opcode [31:27], rd [25:22], rs1 [21:18].
- ra = 4'd15.

Conflict check for a pair (A = `of_instr`, B = a downstream latch):
- Conflict = 0 if A is NOP, BEQ(10000), BGT(10001), B(10010), CALL(10011), NOT(01000) or MOV(01001). These do not read rs1.
- Conflict = 0 if B is NOP, CMP(00101), ST(01111), BEQ, BGT, B or RET(10100). These write no register.
- Otherwise: src = (A==RET) ? ra : A.rs1; dest = (B==CALL) ? ra : B.rd; conflict = (src==dest).
- Only rs1 is interlocked; rs2 and store-data hazards are handled by the forwarding path.

Decision signals:
- `conflict` = check(OF,EX) | check(OF,MA) | check(OF,RW).
- `pc_stall` = conflict & ~branch_taken (combinational).

Per rising edge, in priority order:
1. `branch_taken`: of←NOP_WORD, ex←NOP_WORD, ma←ex, rw←ma. Counter unchanged. Flush wins over a simultaneous conflict.
2. `conflict`: of holds, ex←NOP_WORD, ma←ex, rw←ma. stall_cnt+1, saturating at all-ones.
3. Otherwise: of←if_instr, ex←of, ma←ex, rw←ma.

Consequences:
- A dependence on the immediately preceding producer costs 3 stall cycles.
- Distance 2 costs 2 cycles, distance 3 costs 1 cycle, distance ≥4 costs none.
- A self-dependence (OF instruction's rs1 == its own rd) is not a hazard, since only downstream latches are compared.

## Timing
- Reset (async assert, takes effect immediately): all four latches = NOP_WORD, stall_cnt = 0, so pc_stall = 0.
- Reset deassertion: the first edge after it loads `if_instr` into OF normally.
- Reset mid-stall: the stall is abandoned; no state survives.
- Latency IF→RW is 4 cycles with no hazards.
- `pc_stall` is valid in the same cycle as the latch contents it is derived from. Upstream must sample it before the same edge.
- `branch_taken` must be a same-cycle combinational input from EX. It is sampled only at the edge.
- `stall_cnt` at all-ones stays at all-ones.

## Structure
- Shared package `pipe_pkg`:
  - opcode localparams (NOP, CMP, NOT, MOV, ST, BEQ, BGT, B, CALL, RET);
  - `RA_IDX` = 4'd15;
  - `NOP_WORD`;
  - field bit-position constants.
- Sub-module `raw_pair_check` (combinational; inputs A, B; output conflict), instantiated three times: OF/EX, OF/MA, OF/RW.
- Top level holds the latches, priority mux and counter.

## Test plan
- Reset: assert `rst` mid-run → all latches 32'h6800_0000, stall_cnt 0, pc_stall 0 without waiting for a clock edge.
- Back-to-back RAW: feed 32'h0048_C000 (add r1,r2,r3) then 32'h0105_4000 (add r4,r1,r5) → pc_stall high exactly 3 cycles, 3 NOPs enter EX, stall_cnt = 3, consumer reaches EX on the 4th cycle after reaching OF.
- Distance-3 RAW: producer, two independent adds, then consumer → exactly 1 stall cycle.
- Non-hazard opcodes: consumer replaced by MOV, or producer by CMP (same register fields) → pc_stall never asserts.
- RET after CALL: CALL (opcode 10011) followed by RET (opcode 10100) → 3 stall cycles via ra=15.
- Flush over stall: assert `branch_taken` during a conflict cycle → pc_stall 0, OF and EX become NOP_WORD, stall_cnt not incremented; the next `if_instr` is loaded on the following edge.
